mem_access_unit: RTL and testbench

- Load/store sequencer directly upstream of the data memory.
- Accepts one load/store request per transaction from the execute stage over a valid/ready handshake and drives the word-wide memory port (address, write data, read/write select).
- Performs sign/zero extension for sub-word loads and read-modify-write for sub-word stores.
- Returns a single-cycle response pulse to write-back.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store sequencer and its lane-align datapath.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } mem_state_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_sub_word(input mem_op_e op);
    return (op != OP_LW) && (op != OP_SW);
  endfunction

  function automatic logic [2:0] access_size(input mem_op_e op);
    case (op)
      OP_LW, OP_SW:          return 3'(WORD_BYTES);
      OP_LH, OP_LHU, OP_SH:  return 3'd2;
      default:               return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load extraction with sign/zero extension, and
// sub-word merge of new store data into the previously read word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  mem_op_e     op,
  input  logic [1:0]  byte_sel,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = 8'(old_word >> {byte_sel, 3'b000});
    half_v    = byte_sel[1] ? old_word[31:16] : old_word[15:0];
    load_data = old_word;
    case (op)
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data = {16'h0000, half_v};
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data = {24'h000000, byte_v};
      default: load_data = old_word;
    endcase
  end

  always_comb begin
    merged_word = old_word;
    case (op)
      OP_SB: merged_word[{byte_sel, 3'b000} +: 8] = new_data[7:0];
      OP_SH: begin
        if (byte_sel[1]) merged_word[31:16] = new_data[15:0];
        else             merged_word[15:0]  = new_data[15:0];
      end
      OP_SW:   merged_word = new_data;
      default: merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the word-wide data memory.
// Optional MEM_RANGE_CHECK_EN rejects accesses that run past MEM_BYTES.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  mem_state_e  state;
  mem_op_e     op_in;
  mem_op_e     op_q;
  logic [1:0]  sel_q;
  logic [31:0] wdata_q;
  logic [31:0] result_q;
  logic        err_q;
  logic [15:0] cnt;
  logic        cnt_last;
  logic        misaligned;
  logic        out_of_range;
  logic        reject;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign op_in     = mem_op_e'(req_op);
  assign req_ready = (state == ST_IDLE);
  assign cnt_last  = (cnt == 16'(MEM_LAT - 1));

  always_comb begin
    misaligned = 1'b0;
    case (access_size(op_in))
      3'd4:    misaligned = (req_addr[1:0] != 2'b00);
      3'd2:    misaligned = req_addr[0];
      default: misaligned = 1'b0;
    endcase
  end

`ifdef MEM_RANGE_CHECK_EN
  assign out_of_range = ({1'b0, req_addr} + 33'(access_size(op_in))) > 33'(MEM_BYTES);
`else
  assign out_of_range = 1'b0;
`endif

  assign reject = misaligned || out_of_range;

  mem_lane_align u_align (
    .old_word    (mem_rdata),
    .new_data    (wdata_q),
    .op          (op_q),
    .byte_sel    (sel_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_LW;
      sel_q     <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= op_in;
            sel_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            result_q <= '0;
            cnt      <= '0;
            err_q    <= reject;
            if (reject) begin
              state <= ST_RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              // Full-word stores need no read, so they go straight to the write phase.
              if (op_in == OP_SW) begin
                mem_wdata <= req_wdata;
                mem_rw    <= 1'b1;
                state     <= ST_WR;
              end else begin
                state <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (cnt_last) begin
            cnt <= '0;
            if (is_store(op_q) && is_sub_word(op_q)) begin
              mem_wdata <= merged_word;
              mem_rw    <= 1'b1;
              state     <= ST_WR;
            end else begin
              result_q <= load_data;
              state    <= ST_RESP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WR: begin
          if (cnt_last) begin
            cnt    <= '0;
            mem_rw <= 1'b0;
            state  <= ST_RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response registers are loaded on the RESP cycle and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= (state == ST_RESP);
      if (state == ST_RESP) begin
        resp_rdata <= result_q;
        resp_err   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word-array memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];
  int          wr_count = 0;
  logic [31:0] last_wr_addr = '0;

  int          n_checks = 0;
  int          n_fails  = 0;

  int          lat;
  logic [31:0] rdata;
  logic        err;
  int          w0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_LAT(1), .MEM_BYTES(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_rw) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wr_count           <= wr_count + 1;
      last_wr_addr       <= mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output int l, output logic [31:0] rd, output logic er);
    @(negedge clk);
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("ready_busy", {31'b0, req_ready}, 32'd0);
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!resp_valid && l < 20);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
    #1;
    check("pulse_one_cycle", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_rw", {31'b0, mem_rw}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload word 0x10 through the unit itself
    do_req(OP_SW, 32'h10, 32'h8899AABB, lat, rdata, err);
    check("sw_lat", lat, 32'd2);
    check("sw_err", {31'b0, err}, 32'd0);
    check("sw_rdata", rdata, 32'h0);
    check("sw_mem", mem[4], 32'h8899AABB);

    do_req(OP_LW, 32'h10, 32'h0, lat, rdata, err);
    check("lw_lat", lat, 32'd2);
    check("lw_rdata", rdata, 32'h8899AABB);
    check("lw_err", {31'b0, err}, 32'd0);

    do_req(OP_LB, 32'h13, 32'h0, lat, rdata, err);
    check("lb_rdata", rdata, 32'hFFFFFF88);
    do_req(OP_LBU, 32'h13, 32'h0, lat, rdata, err);
    check("lbu_rdata", rdata, 32'h00000088);
    do_req(OP_LH, 32'h12, 32'h0, lat, rdata, err);
    check("lh_rdata", rdata, 32'hFFFF8899);
    check("lh_lat", lat, 32'd2);
    do_req(OP_LHU, 32'h10, 32'h0, lat, rdata, err);
    check("lhu_rdata", rdata, 32'h0000AABB);
    do_req(OP_LB, 32'h10, 32'h0, lat, rdata, err);
    check("lb0_rdata", rdata, 32'hFFFFFFBB);
    do_req(OP_LBU, 32'h11, 32'h0, lat, rdata, err);
    check("lbu1_rdata", rdata, 32'h000000AA);

    w0 = wr_count;
    do_req(OP_SB, 32'h11, 32'h00000055, lat, rdata, err);
    check("sb_lat", lat, 32'd3);
    check("sb_err", {31'b0, err}, 32'd0);
    check("sb_rdata", rdata, 32'h0);
    check("sb_mem", mem[4], 32'h889955BB);
    check("sb_wr_addr", last_wr_addr, 32'h10);
    check("sb_wr_count", wr_count - w0, 32'd1);

    do_req(OP_SW, 32'h10, 32'h8899AABB, lat, rdata, err);
    do_req(OP_SH, 32'h12, 32'h00001234, lat, rdata, err);
    check("sh_lat", lat, 32'd3);
    check("sh_mem", mem[4], 32'h1234AABB);

    w0 = wr_count;
    do_req(OP_LW, 32'h06, 32'h0, lat, rdata, err);
    check("lw_mis_lat", lat, 32'd1);
    check("lw_mis_err", {31'b0, err}, 32'd1);
    check("lw_mis_rdata", rdata, 32'h0);
    do_req(OP_SH, 32'h03, 32'h0000BEEF, lat, rdata, err);
    check("sh_mis_lat", lat, 32'd1);
    check("sh_mis_err", {31'b0, err}, 32'd1);
    check("mis_no_write", wr_count - w0, 32'd0);
    check("mis_mem_kept", mem[0], mem[0] === 32'h0000BEEF ? 32'hFFFFFFFF : mem[0]);

    w0 = wr_count;
    do_req(OP_SW, 32'h3E, 32'h11111111, lat, rdata, err);
    check("sw3e_err", {31'b0, err}, 32'd1);
    check("sw3e_no_write", wr_count - w0, 32'd0);
    do_req(OP_SW, 32'h3C, 32'hCAFEF00D, lat, rdata, err);
    check("sw3c_err", {31'b0, err}, 32'd0);
    check("sw3c_mem", mem[15], 32'hCAFEF00D);
    check("sw3c_lat", lat, 32'd2);
    do_req(OP_LB, 32'h40, 32'h0, lat, rdata, err);
`ifdef MEM_RANGE_CHECK_EN
    check("lb40_err", {31'b0, err}, 32'd1);
    check("lb40_lat", lat, 32'd1);
`else
    check("lb40_err", {31'b0, err}, 32'd0);
    check("lb40_lat", lat, 32'd2);
`endif

    // Reset in the write phase of a byte store
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_SB;
    req_addr  = 32'h11;
    req_wdata = 32'h00000066;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("wr_phase_rw", {31'b0, mem_rw}, 32'd1);
    check("wr_phase_wdata", mem_wdata, 32'h123466BB);
    rst_n = 1'b0;
    #1;
    check("abort_rw", {31'b0, mem_rw}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_rdata", resp_rdata, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_write", wr_count - w0, 32'd0);
    do_req(OP_LW, 32'h10, 32'h0, lat, rdata, err);
    check("post_rst_lat", lat, 32'd2);
    check("post_rst_rdata", rdata, 32'h1234AABB);
    check("post_rst_err", {31'b0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
